// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the SRAM bus arbiter slice.
//   state_t : arbiter sequencer states (3-bit encoding)
//   port_t  : requester IDs; PORT_C = core data port, PORT_L = loader
//   DEF_*   : default address/data widths and wait-phase timeout
package core_bus_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_HI = 3'd1,
    WAIT_LO = 3'd2,
    ERR     = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_L = 1'b1
  } port_t;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// Bundle of the two requester ports and the SRAM handshake port.
//   c_* : core data port (req/we/addr/wdata in; rdata/ack/err out)
//   l_* : loader port, same shape as c_*
//   m_* : SRAM port (start/we/addr/wdata out; rdata/busy in)
//   owner : last/current grant (0 = core, 1 = loader)
// Modport master is the arbiter's view (it masters the SRAM);
// modport slave is the view of the surrounding requesters and memory.
interface sram_bus_arbiter_if
  import core_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] c_rdata;
  logic              c_ack;
  logic              c_err;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic [DATA_W-1:0] l_rdata;
  logic              l_ack;
  logic              l_err;

  logic              m_start;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_busy;

  logic              owner;

  modport master (
    input  c_req, c_we, c_addr, c_wdata,
    output c_rdata, c_ack, c_err,
    input  l_req, l_we, l_addr, l_wdata,
    output l_rdata, l_ack, l_err,
    output m_start, m_we, m_addr, m_wdata,
    input  m_rdata, m_busy,
    output owner
  );

  modport slave (
    output c_req, c_we, c_addr, c_wdata,
    input  c_rdata, c_ack, c_err,
    output l_req, l_we, l_addr, l_wdata,
    input  l_rdata, l_ack, l_err,
    input  m_start, m_we, m_addr, m_wdata,
    output m_rdata, m_busy,
    input  owner
  );

endinterface

// File: rtl/sram_bus_arbiter_rr_arb2.sv
// Two-input round-robin picker, purely combinational.
//   i_req[0] : core request, i_req[1] : loader request
//   i_last   : previous winner (port ID)
//   o_gnt    : winning port ID, meaningful when o_valid
//   o_valid  : at least one request present
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_gnt,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    // A lone request wins outright; on a tie the port that did not win last time goes.
    o_gnt   = i_req[1];
    if (&i_req) begin
      o_gnt = ~i_last;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the single data SRAM between the core data port and the loader.
// Each access runs start strobe -> busy high -> busy low, then a one-cycle ack
// with read data goes to the winner. A per-phase watchdog converts a hung
// handshake into an error ack.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester + SRAM bundle (master modport)
module sram_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  sram_bus_arbiter_if.master bus
);

  localparam int unsigned       CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_owner;
  logic              r_start;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic [DATA_W-1:0] r_c_rdata;
  logic [DATA_W-1:0] r_l_rdata;
  logic              r_c_ack;
  logic              r_c_err;
  logic              r_l_ack;
  logic              r_l_err;

  logic              w_gnt;
  logic              w_valid;
  logic              w_cnt_max;

  rr_arb2 u_arb (
    .i_req   ({bus.l_req, bus.c_req}),
    .i_last  (r_owner),
    .o_gnt   (w_gnt),
    .o_valid (w_valid)
  );

  // Counter saturates at TIMEOUT: the phase times out instead of incrementing past it.
  assign w_cnt_max = (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_owner   <= PORT_L;
      r_start   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_c_rdata <= '0;
      r_l_rdata <= '0;
      r_c_ack   <= 1'b0;
      r_c_err   <= 1'b0;
      r_l_ack   <= 1'b0;
      r_l_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid && !bus.m_busy) begin
            r_m_addr  <= w_gnt ? bus.l_addr  : bus.c_addr;
            r_m_we    <= w_gnt ? bus.l_we    : bus.c_we;
            r_m_wdata <= w_gnt ? bus.l_wdata : bus.c_wdata;
            r_start   <= 1'b1;
            r_owner   <= w_gnt;
            r_cnt     <= '0;
            r_state   <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          r_start <= 1'b0;
          if (bus.m_busy) begin
            r_cnt   <= '0;
            r_state <= WAIT_LO;
          end else if (w_cnt_max) begin
            r_state <= ERR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (!bus.m_busy) begin
            if (r_owner == PORT_L) begin
              r_l_rdata <= bus.m_rdata;
              r_l_ack   <= 1'b1;
              r_l_err   <= 1'b0;
            end else begin
              r_c_rdata <= bus.m_rdata;
              r_c_ack   <= 1'b1;
              r_c_err   <= 1'b0;
            end
            r_state <= DONE;
          end else if (w_cnt_max) begin
            r_state <= ERR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ERR: begin
          if (r_owner == PORT_L) begin
            r_l_rdata <= '0;
            r_l_ack   <= 1'b1;
            r_l_err   <= 1'b1;
          end else begin
            r_c_rdata <= '0;
            r_c_ack   <= 1'b1;
            r_c_err   <= 1'b1;
          end
          r_state <= DONE;
        end
        DONE: begin
          r_c_ack <= 1'b0;
          r_c_err <= 1'b0;
          r_l_ack <= 1'b0;
          r_l_err <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.c_rdata = r_c_rdata;
  assign bus.c_ack   = r_c_ack;
  assign bus.c_err   = r_c_err;
  assign bus.l_rdata = r_l_rdata;
  assign bus.l_ack   = r_l_ack;
  assign bus.l_err   = r_l_err;
  assign bus.m_start = r_start;
  assign bus.m_we    = r_m_we;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_wdata = r_m_wdata;
  assign bus.owner   = r_owner;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with a behavioural SRAM that raises busy
// the cycle after m_start for MEM_B cycles.
module tb_sram_bus_arbiter;
  import core_bus_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned TO    = 8;
  localparam int unsigned MEM_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sram_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM
  int unsigned mem_cnt    = 0;
  bit          mem_dead   = 1'b0;
  bit          force_busy = 1'b0;
  logic [31:0] rd_val     = '0;

  always @(posedge clk) begin
    if (bus.m_start && !mem_dead) mem_cnt <= MEM_B;
    else if (mem_cnt != 0)        mem_cnt <= mem_cnt - 1;
  end
  assign bus.m_busy  = force_busy | (mem_cnt != 0);
  assign bus.m_rdata = rd_val;

  int n_ovl = 0;
  always @(negedge clk) if (bus.c_ack && bus.l_ack) n_ovl++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Presents one request from an idle arbiter; times are edges after presentation.
  task automatic do_txn(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int t_start, output int t_ack,
                        output logic [31:0] rdata, output logic err);
    t_start = -1;
    t_ack   = -1;
    rdata   = '0;
    err     = 1'b0;
    @(posedge clk); #1;
    if (port) begin
      bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wdata;
    end else begin
      bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata;
    end
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus.m_start && t_start < 0) t_start = k;
      if (port ? bus.l_ack : bus.c_ack) begin
        t_ack = k;
        rdata = port ? bus.l_rdata : bus.c_rdata;
        err   = port ? bus.l_err : bus.c_err;
        break;
      end
    end
    bus.c_req = 1'b0;
    bus.l_req = 1'b0;
  endtask

  int          ts, ta, ng, na, seen, k_ack;
  logic [31:0] rd;
  logic        er;
  logic        g_own [4];
  logic        g_we  [4];
  logic [31:0] g_addr[4];
  logic [31:0] g_wd  [4];
  int          g_st  [4];
  logic        a_port[4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_c_ack",   32'(bus.c_ack),   32'd0);
    check_val("rst_l_ack",   32'(bus.l_ack),   32'd0);
    check_val("rst_m_start", 32'(bus.m_start), 32'd0);
    check_val("rst_owner",   32'(bus.owner),   32'd1);
    check_val("rst_m_addr",  bus.m_addr,       32'd0);
    check_val("rst_c_rdata", bus.c_rdata,      32'd0);
    apply_reset();

    // Core read after reset
    rd_val = 32'hDEADBEEF;
    do_txn(PORT_C, 1'b0, 32'h10, 32'h0, ts, ta, rd, er);
    check_val("c_rd_start", 32'(ts), 32'd1);
    check_val("c_rd_ack",   32'(ta), 32'd6);
    check_val("c_rd_data",  rd,      32'hDEADBEEF);
    check_val("c_rd_err",   32'(er), 32'd0);
    check_val("c_rd_owner", 32'(bus.owner), 32'd0);
    check_val("c_rd_maddr_hold", bus.m_addr, 32'h10);
    check_val("c_rd_mwe",   32'(bus.m_we), 32'd0);

    // Both requesters held for four transactions
    apply_reset();
    rd_val = 32'h12345678;
    @(posedge clk); #1;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h30; bus.c_wdata = 32'h0;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h20; bus.l_wdata = 32'hA5A50001;
    ng = 0; na = 0;
    for (int k = 1; k <= 100 && na < 4; k++) begin
      @(posedge clk); #1;
      if (bus.m_start && ng < 4) begin
        g_own[ng] = bus.owner; g_we[ng] = bus.m_we; g_addr[ng] = bus.m_addr;
        g_wd[ng] = bus.m_wdata; g_st[ng] = k; ng++;
      end
      if (bus.c_ack)      begin a_port[na] = 1'b0; na++; end
      else if (bus.l_ack) begin a_port[na] = 1'b1; na++; end
    end
    bus.c_req = 1'b0; bus.l_req = 1'b0; bus.l_we = 1'b0;
    check_val("rr_num_acks", 32'(na), 32'd4);
    check_val("rr_num_grants", 32'(ng), 32'd4);
    for (int i = 0; i < 4 && i < ng && i < na; i++) begin
      check_val($sformatf("rr_owner%0d", i), 32'(g_own[i]),  32'(i % 2));
      check_val($sformatf("rr_ack%0d", i),   32'(a_port[i]), 32'(i % 2));
      check_val($sformatf("rr_mwe%0d", i),   32'(g_we[i]),   32'(i % 2));
      check_val($sformatf("rr_maddr%0d", i), g_addr[i], (i % 2 == 1) ? 32'h20 : 32'h30);
      if (i % 2 == 1) check_val($sformatf("rr_mwdata%0d", i), g_wd[i], 32'hA5A50001);
    end
    if (ng == 4) begin
      check_val("rr_spacing01", 32'(g_st[1] - g_st[0]), 32'(MEM_B + 4));
      check_val("rr_spacing23", 32'(g_st[3] - g_st[2]), 32'(MEM_B + 4));
    end

    // Timeout on the loader, then a normal loader read
    mem_dead = 1'b1;
    do_txn(PORT_L, 1'b0, 32'h44, 32'h0, ts, ta, rd, er);
    check_val("to_start", 32'(ts), 32'd1);
    check_val("to_ack",   32'(ta), 32'd11);
    check_val("to_err",   32'(er), 32'd1);
    check_val("to_rdata", rd,      32'd0);
    mem_dead = 1'b0;
    do_txn(PORT_L, 1'b0, 32'h48, 32'h0, ts, ta, rd, er);
    check_val("after_to_ack",   32'(ta), 32'd6);
    check_val("after_to_err",   32'(er), 32'd0);
    check_val("after_to_rdata", rd,      32'h12345678);

    // Memory busy while idle
    @(posedge clk); #1;
    force_busy = 1'b1;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h50;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.m_start) seen++;
    end
    check_val("busy_no_start", 32'(seen), 32'd0);
    force_busy = 1'b0;
    @(posedge clk); #1;
    check_val("busy_start_after", 32'(bus.m_start), 32'd1);
    k_ack = -1;
    for (int k = 2; k <= 30; k++) begin
      @(posedge clk); #1;
      if (bus.c_ack) begin k_ack = k; break; end
    end
    bus.c_req = 1'b0;
    check_val("busy_ack", 32'(k_ack), 32'd6);

    // Reset during WAIT_LO
    @(posedge clk); #1;
    rd_val = 32'h0BADF00D;
    bus.c_req = 1'b1; bus.c_addr = 32'h60;
    repeat (3) @(posedge clk);
    #1;
    check_val("rmid_busy", 32'(bus.m_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rmid_m_start", 32'(bus.m_start), 32'd0);
    check_val("rmid_c_ack",   32'(bus.c_ack),   32'd0);
    check_val("rmid_owner",   32'(bus.owner),   32'd1);
    check_val("rmid_m_addr",  bus.m_addr,       32'd0);
    check_val("rmid_c_rdata", bus.c_rdata,      32'd0);
    rst = 1'b0;
    bus.c_req = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.c_ack || bus.l_ack || bus.m_start) seen++;
    end
    check_val("rmid_no_ack", 32'(seen), 32'd0);
    do_txn(PORT_C, 1'b0, 32'h64, 32'h0, ts, ta, rd, er);
    check_val("rmid_new_ack",   32'(ta), 32'd6);
    check_val("rmid_new_rdata", rd,      32'h0BADF00D);
    check_val("rmid_new_err",   32'(er), 32'd0);

    check_val("no_ack_overlap", 32'(n_ovl), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
